squares_arbiter: RTL and testbench
==================================

SQUARES_ARBITER -- requirements
Module: squares_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data bus.
REQ-002 Parameter NUM_CH, default 2, legal 2..4: number of requester streams sharing one sum-of-squares accumulator.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 s_data  in  NUM_CH*DATA_WIDTH  requester beats; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 s_valid / s_last  in  NUM_CH each  per-channel AXI-stream valid and packet end.
REQ-007 s_ready  out  NUM_CH  per-channel ready.
REQ-008 acc_in_data / acc_in_valid / acc_in_last  out  DATA_WIDTH/1/1  stream to accumulator.
REQ-009 acc_in_ready  in  1  accumulator ready.
REQ-010 acc_out_data / acc_out_valid  in  DATA_WIDTH/1  accumulator result; acc_out_ready  out  1.
REQ-011 res_data  out  DATA_WIDTH  result bus shared by all channels; res_valid  out  NUM_CH; res_ready  in  NUM_CH.
REQ-012 grant_id  out  2  currently granted channel; busy  out  1  high in any state other than IDLE.
REQ-013 beat_count  out  16  beats accepted in the current or most recent packet.

Function
REQ-014 FSM states SHALL be IDLE, STREAM, WAIT_RES; one packet in flight at a time.
REQ-015 IDLE: all s_ready, acc_in_valid, acc_out_ready, res_valid low; when any s_valid is high, grant the first channel with s_valid high searching cyclically from last_grant+1, register grant_id, clear beat_count, go to STREAM next cycle.
REQ-016 Arbitration costs exactly one cycle; the first beat can be accepted no earlier than the cycle after the grant decision.
REQ-017 STREAM: acc_in_data/valid/last SHALL combinationally equal s_data/s_valid/s_last of grant_id; s_ready[grant_id] = acc_in_ready; all other s_ready low.
REQ-018 Every s_valid&s_ready beat on the granted channel SHALL increment beat_count, saturating at 16'hFFFF.
REQ-019 A handshaken beat with s_last high SHALL move the FSM to WAIT_RES; a single-beat packet is legal.
REQ-020 WAIT_RES: res_data = acc_out_data; res_valid[grant_id] = acc_out_valid, other res_valid low; acc_out_ready = res_ready[grant_id]; no s_ready asserted.
REQ-021 On acc_out_valid&acc_out_ready: last_grant <= grant_id, FSM to IDLE; res_ready low holds WAIT_RES indefinitely.
REQ-022 Valid/last on non-granted channels SHALL be ignored and left pending; no beat is dropped or reordered.
REQ-023 With continuous requests on all channels, grants SHALL rotate strictly 0,1,..,NUM_CH-1,0; no channel waits more than NUM_CH-1 packets.
REQ-024 grant_id and beat_count hold their values in IDLE until the next grant.
REQ-025 No combinational path from res_ready to s_ready or from s_valid to acc_out_ready.

Reset
REQ-026 rst high at an edge: FSM to IDLE, last_grant = NUM_CH-1 (channel 0 wins first), grant_id = 0, beat_count = 0, busy = 0; all ready/valid outputs low the following cycle.
REQ-027 Reset mid-packet or in WAIT_RES abandons the packet; the accumulator SHALL share the same rst so both restart empty.

Verification
REQ-028 Ch0 sends 3,4 (last on 4), res_ready=1 -> acc_in sees 3 then 4, res_valid[0] with res_data=25, beat_count=2, back to IDLE.
REQ-029 Ch0 and ch1 both valid out of reset, each 1-beat packet (2, 5) -> ch0 result 4 first, then ch1 result 25; grant_id 0 then 1.
REQ-030 Ch1 packet in flight while ch0 asserts valid -> s_ready[0] stays low until ch1 result consumed; ch0 then granted and its data intact.
REQ-031 WAIT_RES with res_ready[0]=0 for 10 cycles -> res_valid[0] and res_data=value held stable, no new grant, busy=1.
REQ-032 rst asserted after 2 beats of a 4-beat ch0 packet -> next cycle IDLE, all outputs at reset values; fresh packet 1,1 (last) yields result 2.

Source files
------------

// File: rtl/squares_arbiter.sv
// Round-robin arbiter that shares one sum-of-squares accumulator
// between NUM_CH packet streams, one packet in flight at a time.
module squares_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]            s_valid,
    input  logic [NUM_CH-1:0]            s_last,
    output logic [NUM_CH-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]        acc_in_data,
    output logic                         acc_in_valid,
    output logic                         acc_in_last,
    input  logic                         acc_in_ready,
    input  logic [DATA_WIDTH-1:0]        acc_out_data,
    input  logic                         acc_out_valid,
    output logic                         acc_out_ready,
    output logic [DATA_WIDTH-1:0]        res_data,
    output logic [NUM_CH-1:0]            res_valid,
    input  logic [NUM_CH-1:0]            res_ready,
    output logic [1:0]                   grant_id,
    output logic                         busy,
    output logic [15:0]                  beat_count
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              last_grant;
    logic [1:0]              pick;
    logic                    found;
    logic [NUM_CH-1:0]       grant_oh;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    sel_res_ready;
    logic                    beat_fire;
    logic                    res_fire;

    // Granted-channel mux; constant indices keep every select in range.
    always_comb begin
        grant_oh      = '0;
        sel_data      = '0;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_res_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_id == 2'(i)) begin
                grant_oh[i]   = 1'b1;
                sel_data      = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid     = s_valid[i];
                sel_last      = s_last[i];
                sel_res_ready = res_ready[i];
            end
        end
    end

    // Cyclic search starting just after the last served channel.
    always_comb begin
        int c;
        c     = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (int'(last_grant) + k) % NUM_CH;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && i == c && s_valid[i]) begin
                    pick  = 2'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign beat_fire = (state == STREAM) && sel_valid && acc_in_ready;
    assign res_fire  = (state == WAIT_RES) && acc_out_valid && sel_res_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'(NUM_CH - 1);
            grant_id   <= '0;
            beat_count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                grant_id   <= pick;
                beat_count <= '0;
            end
            if (beat_fire && beat_count != 16'hFFFF) begin
                beat_count <= beat_count + 16'd1;
            end
            if (res_fire) begin
                last_grant <= grant_id;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (found) state_next = STREAM;
            STREAM:   if (beat_fire && sel_last) state_next = WAIT_RES;
            WAIT_RES: if (res_fire) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready       = '0;
        acc_in_data   = '0;
        acc_in_valid  = 1'b0;
        acc_in_last   = 1'b0;
        acc_out_ready = 1'b0;
        res_data      = '0;
        res_valid     = '0;
        unique case (state)
            STREAM: begin
                s_ready      = grant_oh & {NUM_CH{acc_in_ready}};
                acc_in_data  = sel_data;
                acc_in_valid = sel_valid;
                acc_in_last  = sel_last;
            end
            WAIT_RES: begin
                res_data      = acc_out_data;
                res_valid     = grant_oh & {NUM_CH{acc_out_valid}};
                acc_out_ready = sel_res_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_squares_arbiter.sv
// Directed bench for squares_arbiter with a behavioural
// sum-of-squares accumulator attached to the acc_in/acc_out ports.
module tb_squares_arbiter;

    localparam int DW = 32;
    localparam int NC = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NC*DW-1:0] s_data;
    logic [NC-1:0]  s_valid;
    logic [NC-1:0]  s_last;
    logic [NC-1:0]  s_ready;
    logic [DW-1:0]  acc_in_data;
    logic           acc_in_valid;
    logic           acc_in_last;
    logic           acc_in_ready;
    logic [DW-1:0]  acc_out_data;
    logic           acc_out_valid;
    logic           acc_out_ready;
    logic [DW-1:0]  res_data;
    logic [NC-1:0]  res_valid;
    logic [NC-1:0]  res_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic [15:0]    beat_count;
    logic [DW-1:0]  acc_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    squares_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .acc_in_data(acc_in_data),
        .acc_in_valid(acc_in_valid),
        .acc_in_last(acc_in_last),
        .acc_in_ready(acc_in_ready),
        .acc_out_data(acc_out_data),
        .acc_out_valid(acc_out_valid),
        .acc_out_ready(acc_out_ready),
        .res_data(res_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .grant_id(grant_id),
        .busy(busy),
        .beat_count(beat_count)
    );

    // Accumulator shares rst with the arbiter.
    always @(posedge clk) begin
        if (rst) begin
            acc_sum       <= '0;
            acc_out_data  <= '0;
            acc_out_valid <= 1'b0;
        end else begin
            if (acc_out_valid && acc_out_ready) acc_out_valid <= 1'b0;
            if (acc_in_valid && acc_in_ready) begin
                if (acc_in_last) begin
                    acc_out_data  <= acc_sum + acc_in_data * acc_in_data;
                    acc_out_valid <= 1'b1;
                    acc_sum       <= '0;
                end else begin
                    acc_sum <= acc_sum + acc_in_data * acc_in_data;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive(input int ch, input logic [DW-1:0] d,
                         input logic v, input logic l);
        s_data[ch*DW +: DW] = d;
        s_valid[ch] = v;
        s_last[ch]  = l;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || beat_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b grant=%0d beats=%0d want 0/0/0",
                     busy, grant_id, beat_count);
        end
        checks++;
        if (s_ready !== 2'b00 || acc_in_valid !== 1'b0 ||
            res_valid !== 2'b00 || acc_out_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshakes: s_ready=%b acc_in_valid=%b res_valid=%b acc_out_ready=%b want all 0",
                     s_ready, acc_in_valid, res_valid, acc_out_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_packet;
        drive(0, 3, 1, 0);
        settle;
        checks++;
        if (s_ready !== 2'b00) begin
            errors++;
            $display("FAIL arb_cycle_ready: got %b want 00", s_ready);
        end
        step;
        checks++;
        if (grant_id !== 2'd0 || s_ready !== 2'b01 ||
            acc_in_valid !== 1'b1 || acc_in_data !== 32'd3) begin
            errors++;
            $display("FAIL stream_first: grant=%0d s_ready=%b valid=%b data=%0d want 0/01/1/3",
                     grant_id, s_ready, acc_in_valid, acc_in_data);
        end
        acc_in_ready = 1'b0;
        settle;
        checks++;
        if (s_ready !== 2'b00) begin
            errors++;
            $display("FAIL backpressure_ready: got %b want 00", s_ready);
        end
        step;
        checks++;
        if (beat_count !== 16'd0) begin
            errors++;
            $display("FAIL stall_beats: got %0d want 0", beat_count);
        end
        acc_in_ready = 1'b1;
        step;
        drive(0, 4, 1, 1);
        settle;
        checks++;
        if (acc_in_data !== 32'd4 || acc_in_last !== 1'b1 || beat_count !== 16'd1) begin
            errors++;
            $display("FAIL stream_second: data=%0d last=%b beats=%0d want 4/1/1",
                     acc_in_data, acc_in_last, beat_count);
        end
        step;
        drive(0, 0, 0, 0);
        settle;
        checks++;
        if (res_valid !== 2'b01 || res_data !== 32'd25 ||
            beat_count !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_result: res_valid=%b data=%0d beats=%0d busy=%b want 01/25/2/1",
                     res_valid, res_data, beat_count, busy);
        end
        step;
        checks++;
        if (busy !== 1'b0 || beat_count !== 16'd2 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b beats=%0d grant=%0d want 0/2/0",
                     busy, beat_count, grant_id);
        end
    endtask

    task automatic test_two_channels;
        rst = 1'b1;
        step;
        rst = 1'b0;
        drive(0, 2, 1, 1);
        drive(1, 5, 1, 1);
        step;
        checks++;
        if (grant_id !== 2'd0 || s_ready !== 2'b01) begin
            errors++;
            $display("FAIL first_grant: grant=%0d s_ready=%b want 0/01", grant_id, s_ready);
        end
        step;
        drive(0, 0, 0, 0);
        settle;
        checks++;
        if (res_valid !== 2'b01 || res_data !== 32'd4) begin
            errors++;
            $display("FAIL ch0_result: res_valid=%b data=%0d want 01/4", res_valid, res_data);
        end
        step;
        checks++;
        if (busy !== 1'b0 || s_ready !== 2'b00) begin
            errors++;
            $display("FAIL rearb_idle: busy=%b s_ready=%b want 0/00", busy, s_ready);
        end
        step;
        checks++;
        if (grant_id !== 2'd1 || s_ready !== 2'b10) begin
            errors++;
            $display("FAIL second_grant: grant=%0d s_ready=%b want 1/10", grant_id, s_ready);
        end
        step;
        drive(1, 0, 0, 0);
        settle;
        checks++;
        if (res_valid !== 2'b10 || res_data !== 32'd25) begin
            errors++;
            $display("FAIL ch1_result: res_valid=%b data=%0d want 10/25", res_valid, res_data);
        end
        step;
    endtask

    task automatic test_pending_hold;
        drive(1, 6, 1, 0);
        step;
        drive(0, 7, 1, 1);
        settle;
        checks++;
        if (grant_id !== 2'd1 || s_ready !== 2'b10) begin
            errors++;
            $display("FAIL ch1_inflight: grant=%0d s_ready=%b want 1/10", grant_id, s_ready);
        end
        step;
        drive(1, 1, 1, 1);
        step;
        drive(1, 0, 0, 0);
        res_ready = 2'b00;
        settle;
        checks++;
        if (s_ready !== 2'b00 || res_valid !== 2'b10 ||
            res_data !== 32'd37 || acc_out_ready !== 1'b0) begin
            errors++;
            $display("FAIL pending_wait: s_ready=%b res_valid=%b data=%0d acc_out_ready=%b want 00/10/37/0",
                     s_ready, res_valid, res_data, acc_out_ready);
        end
        step;
        res_ready = 2'b11;
        step;
        step;
        checks++;
        if (grant_id !== 2'd0 || acc_in_data !== 32'd7 || acc_in_last !== 1'b1) begin
            errors++;
            $display("FAIL pending_intact: grant=%0d data=%0d last=%b want 0/7/1",
                     grant_id, acc_in_data, acc_in_last);
        end
        step;
        drive(0, 0, 0, 0);
        settle;
        checks++;
        if (res_valid !== 2'b01 || res_data !== 32'd49) begin
            errors++;
            $display("FAIL pending_result: res_valid=%b data=%0d want 01/49", res_valid, res_data);
        end
        step;
    endtask

    task automatic test_wait_res_stall;
        res_ready = 2'b10;
        drive(0, 3, 1, 1);
        step;
        drive(1, 2, 1, 1);
        step;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (res_valid !== 2'b01 || res_data !== 32'd9 || busy !== 1'b1 ||
                grant_id !== 2'd0 || s_ready !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold[%0d]: res_valid=%b data=%0d busy=%b grant=%0d s_ready=%b want 01/9/1/0/00",
                         i, res_valid, res_data, busy, grant_id, s_ready);
            end
            step;
        end
        res_ready = 2'b11;
        step;
        step;
        checks++;
        if (grant_id !== 2'd1) begin
            errors++;
            $display("FAIL after_stall_grant: got %0d want 1", grant_id);
        end
        step;
        drive(1, 0, 0, 0);
        settle;
        checks++;
        if (res_valid !== 2'b10 || res_data !== 32'd4) begin
            errors++;
            $display("FAIL after_stall_result: res_valid=%b data=%0d want 10/4", res_valid, res_data);
        end
        step;
    endtask

    task automatic test_reset_mid_packet;
        drive(0, 1, 1, 0);
        step;
        step;
        drive(0, 2, 1, 0);
        step;
        checks++;
        if (beat_count !== 16'd2) begin
            errors++;
            $display("FAIL mid_beats: got %0d want 2", beat_count);
        end
        drive(0, 3, 1, 0);
        rst = 1'b1;
        step;
        checks++;
        if (busy !== 1'b0 || beat_count !== 16'd0 || grant_id !== 2'd0 ||
            s_ready !== 2'b00 || acc_in_valid !== 1'b0 ||
            res_valid !== 2'b00 || acc_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b beats=%0d grant=%0d s_ready=%b acc_in_valid=%b res_valid=%b acc_out_valid=%b want all 0",
                     busy, beat_count, grant_id, s_ready, acc_in_valid, res_valid, acc_out_valid);
        end
        rst = 1'b0;
        drive(0, 1, 1, 0);
        drive(1, 9, 1, 1);
        step;
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_grant: got %0d want 0", grant_id);
        end
        step;
        drive(0, 1, 1, 1);
        step;
        drive(0, 0, 0, 0);
        settle;
        checks++;
        if (res_valid !== 2'b01 || res_data !== 32'd2 || beat_count !== 16'd2) begin
            errors++;
            $display("FAIL fresh_result: res_valid=%b data=%0d beats=%0d want 01/2/2",
                     res_valid, res_data, beat_count);
        end
        step;
        step;
        step;
        drive(1, 0, 0, 0);
        settle;
        checks++;
        if (res_valid !== 2'b10 || res_data !== 32'd81 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL drain_ch1: res_valid=%b data=%0d grant=%0d want 10/81/1",
                     res_valid, res_data, grant_id);
        end
        step;
    endtask

    initial begin
        rst          = 1'b1;
        s_data       = '0;
        s_valid      = '0;
        s_last       = '0;
        acc_in_ready = 1'b1;
        res_ready    = 2'b11;
        test_reset;
        test_single_packet;
        test_two_channels;
        test_pending_hold;
        test_wait_res_stall;
        test_reset_mid_packet;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
